// File: rtl/pipeline_hazard_ctrl.sv
// RF-stage hazard and sequencing controller: detects load-use, CBZ-after-load and
// flag hazards against EX, stalls/bubbles/flushes, and keeps saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int         CNT_W = 16,
    parameter logic [4:0] XZR   = 5'd31
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       rf_rn,
    input  logic [4:0]       rf_rm,
    input  logic             rf_rn_used,
    input  logic             rf_rm_used,
    input  logic             rf_is_cbz,
    input  logic             rf_is_bcond,
    input  logic             rf_brtaken,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic             ex_flagen,
    output logic             pc_write_en,
    output logic             ifrf_write_en,
    output logic             ifrf_flush,
    output logic             rfex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        CBZ_WAIT = 2'b01
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_nxt;

    logic ex_wr;
    logic mn;
    logic mm;
    logic ld_use;
    logic cbz_ld;
    logic flag_hz;
    logic stall;
    logic flush;

    // XZR is never a real producer, so a write to it cannot create a dependency.
    assign ex_wr   = ex_regwrite & (ex_rd != XZR);
    assign mn      = rf_rn_used & ex_wr & (rf_rn == ex_rd);
    assign mm      = rf_rm_used & ex_wr & (rf_rm == ex_rd);
    assign ld_use  = ex_memread & (mn | mm);
    assign cbz_ld  = rf_is_cbz & ex_memread & mm;
    assign flag_hz = rf_is_bcond & ex_flagen;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        state_nxt = state;
        stall     = 1'b0;
        unique case (state)
            RUN: begin
                if (cbz_ld) begin
                    stall     = 1'b1;
                    state_nxt = CBZ_WAIT;
                end else if (ld_use | flag_hz) begin
                    stall = 1'b1;
                end
            end
            CBZ_WAIT: begin
                // Load is in MEM now; its value reaches the zero test by forwarding next cycle.
                stall     = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // A taken branch whose operands are not yet valid must not redirect fetch.
    assign flush = rf_brtaken & ~stall;

    always_comb begin
        pc_write_en   = 1'b1;
        ifrf_write_en = 1'b1;
        ifrf_flush    = 1'b0;
        rfex_bubble   = 1'b0;
        if (!reset_n) begin
            pc_write_en   = 1'b0;
            ifrf_write_en = 1'b0;
            rfex_bubble   = 1'b1;
        end else if (stall) begin
            pc_write_en   = 1'b0;
            ifrf_write_en = 1'b0;
            rfex_bubble   = 1'b1;
        end else if (flush) begin
            ifrf_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the register-fetch (RF) stage of the 5-stage ARM-subset pipeline. It detects load-use, CBZ-after-load and flag-dependency hazards against the instruction in EX. On a hazard it freezes PC and IF/RF, and injects a bubble into the RF/EX control registers. On a taken branch resolved in RF, it flushes IF/RF. It also keeps saturating stall and flush counters for performance debug.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt (saturating)
XZR, 31, register index of XZR; never a hazard source

Ports:
clk  input  1  system clock, all state updates on posedge
reset_n  input  1  synchronous active-low reset
rf_rn  input  5  Rn field of instruction in RF (instru[9:5])
rf_rm  input  5  second read register after Reg2Loc mux (Rm or Rd/Rt)
rf_rn_used  input  1  instruction in RF reads Rn (Rn_True)
rf_rm_used  input  1  instruction in RF reads second register (Rm_True)
rf_is_cbz  input  1  instruction in RF is CBZ (zero test done in RF)
rf_is_bcond  input  1  instruction in RF is B.cond (reads flags)
rf_brtaken  input  1  branch-taken decision computed in RF this cycle
ex_rd  input  5  destination register of instruction in EX
ex_memread  input  1  instruction in EX is LDUR
ex_regwrite  input  1  instruction in EX writes a register
ex_flagen  input  1  instruction in EX sets flags
pc_write_en  output  1  PC register enable
ifrf_write_en  output  1  IF/RF pipeline register enable
ifrf_flush  output  1  IF/RF register loads NOP at next edge
rfex_bubble  output  1  zero all control bits into RF/EX at next edge
stall_cnt  output  CNT_W  cycles with a stall asserted, saturating
flush_cnt  output  CNT_W  flushes issued, saturating

Behaviour:
- Clock is clk. Reset is reset_n: synchronous and active-low. While reset_n=0: state<=RUN, stall_cnt<=0, flush_cnt<=0. Outputs are forced as follows during reset: pc_write_en=0, ifrf_write_en=0, ifrf_flush=0, rfex_bubble=1. Outputs take normal values in the first cycle after reset_n goes high.
- Match terms (combinational), with ex_wr = ex_regwrite & (ex_rd != XZR):
  - mn = rf_rn_used & ex_wr & (rf_rn == ex_rd)
  - mm = rf_rm_used & ex_wr & (rf_rm == ex_rd)
- Hazard terms:
  - ld_use = ex_memread & (mn | mm)
  - cbz_ld = rf_is_cbz & ex_memread & mm
  - flag_hz = rf_is_bcond & ex_flagen
- States: RUN, CBZ_WAIT (2-bit encoding, registered).
- RUN:
  - If cbz_ld, stall this cycle and go to CBZ_WAIT.
  - Else if ld_use | flag_hz, stall this cycle and stay in RUN. The next cycle EX holds the bubble, so the hazard clears naturally.
  - Else no stall.
- CBZ_WAIT: stall unconditionally for one cycle, then return to RUN. The load is now in MEM and its value reaches the RF zero test via MEM forwarding next cycle. CBZ after load therefore costs exactly 2 stall cycles.
- stall = (state==RUN & (cbz_ld|ld_use|flag_hz)) | (state==CBZ_WAIT). stall drives pc_write_en=0, ifrf_write_en=0 and rfex_bubble=1; otherwise these are 1, 1 and 0.
- flush = rf_brtaken & ~stall. When flush=1: ifrf_flush=1, pc_write_en=1, ifrf_write_en=1. During a stall rf_brtaken is ignored, because its operands are not yet valid, so stall has priority.
- Outputs are combinational from state and inputs, with latency 0. They gate the same edge that captures RF/EX.
- Counters (registered):
  - stall_cnt += 1 on every stall cycle.
  - flush_cnt += 1 on every flush cycle.
  - Both hold at 2^CNT_W-1 and never wrap.
- Reset mid-CBZ_WAIT returns to RUN immediately. Dropping reset_n does not complete the pending stall.
- Matching on XZR (31) never stalls, even if ex_regwrite=1.

Test Plan:
- Load-use: EX=LDUR X2 (ex_memread=1, ex_rd=2); RF=ADD X3,X2,X4 (rf_rn=2, used) -> exactly 1 cycle with pc_write_en=0 and rfex_bubble=1; stall_cnt=1.
- CBZ after load: EX=LDUR X5; RF=CBZ X5 (rf_is_cbz=1, rf_rm=5) -> 2 consecutive stall cycles (RUN->CBZ_WAIT->RUN); stall_cnt=2; rf_brtaken=1 during both stall cycles -> ifrf_flush stays 0.
- Flag hazard plus branch: EX=ADDS (ex_flagen=1); RF=B.LT with rf_brtaken=1 -> 1 stall, no flush. Next cycle rf_brtaken=1 -> ifrf_flush=1; flush_cnt=1.
- XZR / no-read: EX=LDUR XZR, rf_rn=31, used -> no stall. EX=LDUR X7, rf_rm=7 with rf_rm_used=0 -> no stall.
- Saturation and reset: with CNT_W=4, 20 stall cycles -> stall_cnt=15. Then reset_n=0 for 1 cycle during CBZ_WAIT -> state RUN, counters 0, and rfex_bubble=1 during the reset cycle.
